// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
// Shared types and constants for the SPI register slave.
//   state_t       : protocol FSM states
//   CMD_WRITE_BIT : command byte bit selecting write (1) or read (0)
//   ADDR_W        : register address width
//   NUM_REGS      : register file depth
package spi_slave_pkg;

  localparam int ADDR_W        = 4;
  localparam int NUM_REGS      = 16;
  localparam int CMD_WRITE_BIT = 7;

  // WAIT_CS : after reset, ignore everything until CS_n is seen high
  // IDLE    : deselected, waiting for a CS_n falling edge
  // CMD     : shifting in the command byte
  // DATA    : shifting data bytes (read or write burst)
  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    CMD     = 2'd2,
    DATA    = 2'd3
  } state_t;

endpackage

// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if
// Bundles the SPI pins, the local register port and the write-event outputs
// of spi_slave_regs.
//   slave  modport : the register slave (drives MISO, loc_rdata, evt_*)
//   master modport : the environment (drives SCLK/MOSI/CS_n and loc_*)
interface spi_slave_regs_if;
  import spi_slave_pkg::*;

  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] loc_addr;
  logic              loc_we;
  logic [7:0]        loc_wdata;
  logic [7:0]        loc_rdata;
  logic              evt_valid;
  logic [ADDR_W-1:0] evt_addr;
  logic [7:0]        evt_data;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, loc_addr, loc_we, loc_wdata,
    output spi_miso, spi_miso_oe, loc_rdata, evt_valid, evt_addr, evt_data
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, loc_addr, loc_we, loc_wdata,
    input  spi_miso, spi_miso_oe, loc_rdata, evt_valid, evt_addr, evt_data
  );

endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
// Multi-flop synchroniser for one asynchronous SPI pin, plus single-cycle
// rise/fall pulses derived from the last two synchronised samples.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous input pin
//   level      : synchronised pin value
//   rise, fall : one-cycle pulses on a synchronised 0->1 / 1->0 transition
// STAGES must be at least 2; RESET_VAL is the pin's idle level so that no
// spurious edge is reported while the chain is held in reset.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs
// SPI target exposing a 16 x 8-bit register file. All SPI pins are
// oversampled in the clk domain; SCLK never clocks logic directly.
// Protocol: one command byte (bit7 = write, bits[3:0] = start address)
// followed by an unlimited burst of data bytes, address auto-incrementing
// and wrapping 15 -> 0. MSB first, MOSI captured on SCLK falling edges,
// MISO updated on SCLK rising edges. Register 0 is a read-only ID.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : SPI pins, local register port (loc_*) and commit events (evt_*)
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] REG_RESET   = 8'h00
) (
  input logic             clk,
  input logic             reset,
  spi_slave_regs_if.slave bus
);

  // Cycles after reset before the synchronised CS_n reflects the real pin.
  localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_pins;

  state_t            state, state_next;
  logic [2:0]        flush_cnt;
  logic              flush_done;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_shift;
  logic              is_write;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [7:0]        reg_file [NUM_REGS];
  logic              miso_q;
  logic              evt_valid_q;
  logic [ADDR_W-1:0] evt_addr_q;
  logic [7:0]        evt_data_q;

  logic in_frame, in_read_data, bit_take, byte_done;
  logic cmd_done, data_done, spi_commit, tx_shift_en;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(bus.spi_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin(bus.spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .pin(bus.spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // Only the sampled MOSI level and the SCLK edges drive the protocol.
  assign unused_pins = ^{sclk_level, mosi_rise, mosi_fall};

  assign rx_byte = {rx_shift[6:0], mosi_level};
  assign ptr_inc = ptr + 1'b1;

  // The synchronisers come out of reset at the idle level, so a CS_n that is
  // already low shows up as a fake falling edge a few cycles later. This
  // counter keeps WAIT_CS from trusting CS_n until the chain has flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (!flush_done) begin
      flush_cnt <= flush_cnt + 3'd1;
    end
  end

  assign flush_done = (flush_cnt == FLUSH_CYCLES);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_CS;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A frame in progress at reset release is skipped by
  // leaving WAIT_CS only once CS_n is seen high, never on a falling edge.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_CS: if (flush_done && cs_level) state_next = IDLE;
      IDLE:    if (cs_fall)                state_next = CMD;
      CMD: begin
        if (cs_rise)       state_next = IDLE;
        else if (cmd_done) state_next = DATA;
      end
      DATA:    if (cs_rise)                state_next = IDLE;
      default:                             state_next = WAIT_CS;
    endcase
  end

  // Output / strobe decode. A CS_n rising edge suppresses any bit taken in
  // the same cycle, so a partial byte can never complete as CS_n releases.
  always_comb begin
    in_frame     = ((state == CMD) || (state == DATA)) && !cs_rise;
    in_read_data = (state == DATA) && !is_write;
    bit_take     = in_frame && sclk_fall;
    byte_done    = bit_take && (bit_cnt == 3'd7);
    cmd_done     = byte_done && (state == CMD);
    data_done    = byte_done && (state == DATA);
    spi_commit   = data_done && is_write;
    tx_shift_en  = in_read_data && sclk_rise && !cs_rise;
  end

  // Shift datapath: bit counter, receive/transmit shifters, address pointer
  // and the MISO register. The transmit shifter is loaded at every byte
  // boundary so the next rising edge already has the right MSB available.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      is_write <= 1'b0;
      ptr      <= '0;
      miso_q   <= 1'b0;
    end else begin
      if (bit_take) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end else if (!in_frame) begin
        bit_cnt  <= '0;
      end

      if (cmd_done) begin
        is_write <= rx_byte[CMD_WRITE_BIT];
        ptr      <= rx_byte[ADDR_W-1:0];
        tx_shift <= reg_file[rx_byte[ADDR_W-1:0]];
      end else if (data_done) begin
        ptr      <= ptr_inc;
        tx_shift <= reg_file[ptr_inc];
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (tx_shift_en) begin
        miso_q <= tx_shift[7];
      end else if (!in_read_data) begin
        miso_q <= 1'b0;
      end
    end
  end

  // Register file. Entry 0 holds the ID and is never written. An SPI commit
  // takes priority over a local write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_file[0] <= ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
        reg_file[i] <= REG_RESET;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (spi_commit && (ptr == ADDR_W'(i))) begin
          reg_file[i] <= rx_byte;
        end else if (bus.loc_we && (bus.loc_addr == ADDR_W'(i))) begin
          reg_file[i] <= bus.loc_wdata;
        end
      end
    end
  end

  // Commit event, reported one cycle after the write lands (also for the
  // read-only register 0, so the host side still sees the attempt).
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_addr_q  <= '0;
      evt_data_q  <= '0;
    end else begin
      evt_valid_q <= spi_commit;
      if (spi_commit) begin
        evt_addr_q <= ptr;
        evt_data_q <= rx_byte;
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = ~cs_level;
  assign bus.loc_rdata   = reg_file[bus.loc_addr];
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_addr    = evt_addr_q;
  assign bus.evt_data    = evt_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs
// Self-checking bench for spi_slave_regs. Stimulus tasks drive SPI frames
// and local writes, updating a plain array model of the register file and
// pushing expected read bytes / write events into queues. Independent
// monitors snoop the pins and pop/compare whenever the DUT produces output.
module tb_spi_slave_regs;

  localparam int HALF = 4;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } evt_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_slave_regs_if bus ();

  spi_slave_regs #(
    .SYNC_STAGES(2),
    .ID_VALUE   (8'hA5),
    .REG_RESET  (8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_regs [16];
  logic [7:0] tx_bytes [8];
  evt_t       evt_exp_q [$];
  logic [7:0] rd_exp_q [$];

  // Pin monitor state
  int         mon_bits  = 0;
  int         mon_bytes = 0;
  logic [7:0] mon_mosi  = 8'h00;
  logic [7:0] mon_miso  = 8'h00;
  logic       mon_read  = 1'b0;
  logic       evt_prev  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    model_regs[0] = 8'hA5;
    for (int i = 1; i < 16; i++) model_regs[i] = 8'h00;
  endtask

  // Drives the first nbits (MSB first) of b; data changes with SCLK rising.
  task automatic spi_byte(input logic [7:0] b, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(negedge clk);
      bus.spi_mosi = b[i];
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
      repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // One SPI frame: command then nbytes data bytes from tx_bytes. When
  // abort_bits is non-zero the last data byte is cut after that many bits.
  task automatic applyStimulus(input logic [7:0] cmd, input int nbytes,
                               input int abort_bits);
    logic [3:0] a;
    a = cmd[3:0];
    for (int i = 0; i < nbytes; i++) begin
      if (abort_bits != 0 && i == nbytes - 1) break;
      if (cmd[7]) begin
        evt_exp_q.push_back({a, tx_bytes[i]});
        if (a != 4'd0) model_regs[a] = tx_bytes[i];
      end else begin
        rd_exp_q.push_back(model_regs[a]);
      end
      a = a + 4'd1;
    end
    cs_low();
    spi_byte(cmd, 8);
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(tx_bytes[i], (abort_bits != 0 && i == nbytes - 1) ? abort_bits : 8);
    end
    cs_high();
    checkOutput("miso_oe_idle", {31'd0, bus.spi_miso_oe}, 32'd0);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    bus.loc_we    = 1'b1;
    @(negedge clk);
    bus.loc_we    = 1'b0;
    if (a != 4'd0) model_regs[a] = d;
  endtask

  task automatic check_loc(input logic [3:0] a);
    @(negedge clk);
    bus.loc_addr = a;
    #1;
    checkOutput($sformatf("loc_rdata[%0d]", a), {24'd0, bus.loc_rdata},
                {24'd0, model_regs[a]});
  endtask

  // Single-byte SPI write with a local write landing in the commit cycle.
  // The commit edge is the third clk edge after the last SCLK fall: two
  // synchroniser flops, then the edge is acted upon.
  task automatic concurrent_write(input logic [3:0] spi_a, input logic [7:0] spi_d,
                                  input logic [3:0] loc_a, input logic [7:0] loc_d);
    evt_exp_q.push_back({spi_a, spi_d});
    if (loc_a != 4'd0 && loc_a != spi_a) model_regs[loc_a] = loc_d;
    if (spi_a != 4'd0) model_regs[spi_a] = spi_d;
    cs_low();
    spi_byte({4'h8, spi_a}, 8);
    spi_byte(spi_d, 7);
    @(negedge clk);
    bus.spi_mosi = spi_d[0];
    bus.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    bus.loc_addr  = loc_a;
    bus.loc_wdata = loc_d;
    bus.loc_we    = 1'b1;
    @(negedge clk);
    bus.loc_we    = 1'b0;
    cs_high();
  endtask

  // MISO/MOSI monitor: rebuilds bytes from the pins, decodes the command
  // byte and compares every completed read byte against the scoreboard.
  always @(negedge bus.spi_sclk or posedge bus.spi_cs_n) begin
    if (bus.spi_cs_n === 1'b1) begin
      mon_bits  = 0;
      mon_bytes = 0;
    end else if (bus.spi_cs_n === 1'b0) begin
      mon_mosi = {mon_mosi[6:0], bus.spi_mosi};
      mon_miso = {mon_miso[6:0], bus.spi_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (mon_bytes == 0) begin
          mon_read = ~mon_mosi[7];
          checkOutput("miso_during_cmd", {24'd0, mon_miso}, 32'd0);
        end else if (mon_read) begin
          if (rd_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL miso_read unexpected byte actual=%0h", mon_miso);
          end else begin
            checkOutput("miso_read", {24'd0, mon_miso}, {24'd0, rd_exp_q.pop_front()});
          end
        end else begin
          checkOutput("miso_during_write", {24'd0, mon_miso}, 32'd0);
        end
        checkOutput("miso_oe_active", {31'd0, bus.spi_miso_oe}, 32'd1);
        mon_bytes++;
      end
    end
  end

  // Write-event monitor.
  always @(negedge clk) begin
    evt_t e;
    if (bus.evt_valid === 1'b1) begin
      checkOutput("evt_back_to_back", {31'd0, evt_prev}, 32'd0);
      if (evt_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL evt unexpected actual addr=%0h data=%0h",
                 bus.evt_addr, bus.evt_data);
      end else begin
        e = evt_exp_q.pop_front();
        checkOutput("evt_addr", {28'd0, bus.evt_addr}, {28'd0, e.addr});
        checkOutput("evt_data", {24'd0, bus.evt_data}, {24'd0, e.data});
      end
    end
    evt_prev = (bus.evt_valid === 1'b1);
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] cmd;
    logic [3:0] a;
    int         n;
    int         ab;

    reset         = 1'b1;
    bus.spi_sclk  = 1'b0;
    bus.spi_mosi  = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.loc_addr  = 4'd0;
    bus.loc_we    = 1'b0;
    bus.loc_wdata = 8'h00;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_miso", {31'd0, bus.spi_miso}, 32'd0);
    checkOutput("reset_miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
    checkOutput("reset_evt_valid", {31'd0, bus.evt_valid}, 32'd0);
    checkOutput("reset_evt_addr", {28'd0, bus.evt_addr}, 32'd0);
    checkOutput("reset_evt_data", {24'd0, bus.evt_data}, 32'd0);
    check_loc(4'd0);
    check_loc(4'd7);
    repeat (6) @(negedge clk);

    $display("[TB] read ID register");
    tx_bytes[0] = 8'h00;
    applyStimulus(8'h00, 1, 0);

    $display("[TB] single write then read back");
    tx_bytes[0] = 8'h5C;
    applyStimulus(8'h83, 1, 0);
    check_loc(4'd3);
    tx_bytes[0] = 8'h00;
    applyStimulus(8'h03, 1, 0);

    $display("[TB] burst write wrapping past 15");
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    applyStimulus(8'h8E, 3, 0);
    check_loc(4'd14);
    check_loc(4'd15);
    check_loc(4'd0);

    $display("[TB] aborted write byte");
    tx_bytes[0] = 8'h6B;
    applyStimulus(8'h82, 1, 5);
    check_loc(4'd2);
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
    applyStimulus(8'h72, 2, 0);

    $display("[TB] SPI commit racing local writes");
    concurrent_write(4'd5, 8'h77, 4'd5, 8'h99);
    check_loc(4'd5);
    concurrent_write(4'd9, 8'h42, 4'd10, 8'h24);
    check_loc(4'd9);
    check_loc(4'd10);

    $display("[TB] reset in the middle of a burst");
    evt_exp_q.push_back({4'd1, 8'hAA});
    model_regs[1] = 8'hAA;
    cs_low();
    spi_byte(8'h81, 8);
    spi_byte(8'hAA, 8);
    spi_byte(8'hF0, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      bus.spi_mosi = 1'b1;
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
      repeat (HALF - 1) @(negedge clk);
    end
    spi_byte(8'h3C, 8);
    spi_byte(8'hC3, 8);
    cs_high();
    check_loc(4'd1);
    check_loc(4'd2);
    tx_bytes[0] = 8'h3C;
    applyStimulus(8'h86, 1, 0);
    check_loc(4'd6);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        a = 4'($urandom);
        loc_write(a, 8'($urandom));
        check_loc(4'($urandom));
      end else begin
        cmd = 8'($urandom);
        n   = $urandom_range(1, 4);
        ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
        for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
        applyStimulus(cmd, n, ab);
      end
    end

    for (int i = 0; i < 16; i++) check_loc(4'(i));

    for (int i = 0; i < 200 && (evt_exp_q.size() != 0 || rd_exp_q.size() != 0); i++) begin
      @(negedge clk);
    end
    checkOutput("evt_queue_left", evt_exp_q.size(), 32'd0);
    checkOutput("read_queue_left", rd_exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
